// File: rtl/sr_flag_scheduler.sv
// Round-robin command sequencer for a bank of SR status flags: grants one
// set/clear (or bulk clear) at a time, pulses s/r for one cycle, then verifies q.
module sr_flag_scheduler #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    input  logic                 init,
    input  logic                 clr_err,
    input  logic [NFLAG-1:0]     q_in,
    output logic [NFLAG-1:0]     s_out,
    output logic [NFLAG-1:0]     r_out,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic                 err_verify,
    output logic                 err_range
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    winner_q;
    logic             op_q;
    logic [IDXW-1:0]  idx_q;
    logic             bulk_q;
    logic             inrange_q;
    logic [NFLAG-1:0] s_q;
    logic [NFLAG-1:0] r_q;
    logic [NREQ-1:0]  gnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_verify_q;
    logic             err_range_q;

    logic [IDXW-1:0]  idx_arr [NREQ];
    logic             any_req;
    logic [PW-1:0]    win;
    logic [PW-1:0]    cand;
    logic             win_op;
    logic [IDXW-1:0]  win_idx;
    logic             win_ok;
    logic [NFLAG-1:0] win_onehot;
    logic [NREQ-1:0]  win_gnt;
    logic [NFLAG-1:0] q_shift;

    // Scan from ptr+NREQ-1 down to ptr so the requester closest to ptr is the
    // last one written and therefore wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            idx_arr[k] = idx[k*IDXW +: IDXW];
        end
    end

    assign win_op     = op[win];
    assign win_idx    = idx_arr[win];
    assign win_ok     = int'(win_idx) < NFLAG;
    assign win_onehot = NFLAG'(1) << win_idx;
    assign win_gnt    = NREQ'(1) << win;
    assign q_shift    = q_in >> idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            winner_q     <= '0;
            op_q         <= 1'b0;
            idx_q        <= '0;
            bulk_q       <= 1'b0;
            inrange_q    <= 1'b0;
            s_q          <= '0;
            r_q          <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_verify_q <= 1'b0;
            err_range_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment to
            // the same register in this block overrides an earlier one.
            s_q    <= '0;
            r_q    <= '0;
            gnt_q  <= '0;
            done_q <= 1'b0;

            // Placed before the state logic so an error raised this cycle wins.
            if (clr_err) begin
                err_verify_q <= 1'b0;
                err_range_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (init) begin
                        r_q     <= '1;
                        bulk_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else if (any_req) begin
                        gnt_q     <= win_gnt;
                        op_q      <= win_op;
                        idx_q     <= win_idx;
                        winner_q  <= win;
                        bulk_q    <= 1'b0;
                        inrange_q <= win_ok;
                        if (win_ok) begin
                            s_q <= win_op ? win_onehot : '0;
                            r_q <= win_op ? '0 : win_onehot;
                        end else begin
                            err_range_q <= 1'b1;
                        end
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (bulk_q) begin
                        if (q_in != '0) err_verify_q <= 1'b1;
                    end else begin
                        if (inrange_q && (q_shift[0] != op_q)) err_verify_q <= 1'b1;
                        ptr_q <= PW'((int'(winner_q) + 1) % NREQ);
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_out      = s_q;
    assign r_out      = r_q;
    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_verify = err_verify_q;
    assign err_range  = err_range_q;

endmodule
